// File: rtl/psum_drain_pkg.sv
// Shared types and helpers for the psum drain path.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
//
// Contents:
//   state_t      drain FSM state encoding (IDLE, SEND)
//   idx_width()  lane-index width, $clog2(n) with a floor of 1 bit
//   requant_sat  clamp a sign-extended value into a signed out_w-bit range
package psum_drain_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   // Index width for a bank of n lanes; a single-lane bank still needs a 1-bit index.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int NUM_LANE_DEF = 16;
   localparam int IDX_W_DEF    = idx_width(NUM_LANE_DEF);

   // Saturating requant helper. The caller sign-extends the shifted psum to 64 bits;
   // the result is clamped to [-2^(out_w-1), 2^(out_w-1)-1], so its low out_w bits
   // are the saturated output word.
   function automatic logic signed [63:0] requant_sat(input logic signed [63:0] t,
                                                      input int                  out_w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (out_w - 1));
      if (t > hi) begin
         return hi;
      end else if (t < lo) begin
         return lo;
      end
      return t;
   endfunction

endpackage

// File: rtl/psum_requant.sv
// Requantizer: arithmetic right shift of one psum lane, then narrow to OUT_W bits.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the output follows the input directly.
//
// Ports:
//   psum_i  PSUM_W-bit signed psum lane
//   data_o  OUT_W-bit requantized word
// Build option: PSUM_DRAIN_SAT_EN defined -> saturate into the signed OUT_W range;
// undefined -> wrap-around truncation (keep the low OUT_W bits).
module psum_requant
   import psum_drain_pkg::*;
#(
   parameter int PSUM_W = 32,
   parameter int OUT_W  = 16,
   parameter int SHIFT  = 0
) (
   input  logic [PSUM_W-1:0] psum_i,
   output logic [OUT_W-1:0]  data_o
);

   // Shift result keeps the full PSUM_W width so no magnitude is lost before narrowing.
   logic signed [PSUM_W-1:0] t;
   assign t = $signed(psum_i) >>> SHIFT;

`ifdef PSUM_DRAIN_SAT_EN
   logic signed [63:0] t_wide;
   logic signed [63:0] clamped;
   logic               unused_clamp_hi;

   assign t_wide  = 64'(t);
   assign clamped = requant_sat(t_wide, OUT_W);
   assign data_o  = clamped[OUT_W-1:0];
   // Upper bits of the clamped value are pure sign extension of data_o.
   assign unused_clamp_hi = ^clamped;
`else
   logic unused_t_hi;

   assign data_o = t[OUT_W-1:0];
   // Bits above OUT_W are deliberately dropped (wrap-around).
   assign unused_t_hi = ^t;
`endif

endmodule

// File: rtl/psum_drain.sv
// Drain of the partial-sum accumulator bank: snapshot all lanes, then stream them requantized.
// Latency: drain_start sampled at edge k gives the first out_valid in cycle k+1; NUM_LANE beats best case.
// Backpressure: out_valid/out_ready; out_data/out_last hold while stalled, out_valid never drops early.
//
// Ports:
//   CLK, RST      clock (posedge) and synchronous active-high reset
//   drain_start   request snapshot + drain, honoured only while idle
//   psum_in       accumulator bank, lane i = psum_in[i*PSUM_W +: PSUM_W]
//   acc_flush     combinational flush to the accumulators, aligned with the capture edge
//   out_valid/out_ready/out_data/out_last   output stream, lane 0 first, last on lane NUM_LANE-1
//   busy          high while a drain is in progress
//   done          one-cycle pulse in the cycle after the final handshake
//   err_overrun   sticky until RST: drain_start seen while a drain was in progress
// Build option: PSUM_DRAIN_SAT_EN selects saturation instead of truncation in the requantizer.
module psum_drain
   import psum_drain_pkg::*;
#(
   parameter int NUM_LANE = 16,
   parameter int PSUM_W   = 32,
   parameter int OUT_W    = 16,
   parameter int SHIFT    = 0
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic                         drain_start,
   input  logic [NUM_LANE*PSUM_W-1:0]   psum_in,
   output logic                         acc_flush,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [OUT_W-1:0]             out_data,
   output logic                         out_last,
   output logic                         busy,
   output logic                         done,
   output logic                         err_overrun
);

   localparam int                IDX_W    = idx_width(NUM_LANE);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_LANE - 1);

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q,   idx_d;
   logic               done_q,  done_d;
   logic               err_q,   err_d;
   logic               capture;
   logic [PSUM_W-1:0]  shadow_q [NUM_LANE];
   logic [PSUM_W-1:0]  lane_sel;

   // ------------------------------------------------------------------
   // Next-state and output logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      done_d    = 1'b0;
      err_d     = err_q;
      capture   = 1'b0;
      acc_flush = 1'b0;
      out_valid = 1'b0;
      out_last  = 1'b0;
      busy      = 1'b0;

      case (state_q)
         IDLE: begin
            if (drain_start) begin
               capture = 1'b1;
               idx_d   = '0;
               state_d = SEND;
               // The accumulators clear on the very edge that captures them, so no
               // contribution is lost or counted twice. Reset suppresses the flush.
               acc_flush = ~RST;
            end
         end

         SEND: begin
            out_valid = 1'b1;
            busy      = 1'b1;
            out_last  = (idx_q == LAST_IDX);
            // A start request during a drain (including the final-handshake cycle) is
            // dropped and only recorded.
            if (drain_start) begin
               err_d = 1'b1;
            end
            if (out_ready) begin
               if (idx_q == LAST_IDX) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         idx_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   // Shadow buffer: reset clears it so an aborted drain leaves nothing behind.
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < NUM_LANE; i++) begin
            shadow_q[i] <= '0;
         end
      end else if (capture) begin
         for (int i = 0; i < NUM_LANE; i++) begin
            shadow_q[i] <= psum_in[i*PSUM_W +: PSUM_W];
         end
      end
   end

   // ------------------------------------------------------------------
   // Lane mux and requantizer
   // ------------------------------------------------------------------
   // idx_q never exceeds LAST_IDX, so the select always addresses a real lane.
   assign lane_sel = shadow_q[idx_q];

   psum_requant #(
      .PSUM_W (PSUM_W),
      .OUT_W  (OUT_W),
      .SHIFT  (SHIFT)
   ) u_requant (
      .psum_i (lane_sel),
      .data_o (out_data)
   );

   assign done        = done_q;
   assign err_overrun = err_q;

endmodule

// File: tb/tb_psum_drain.sv
// Bench for psum_drain: two instances (SHIFT=0 and SHIFT=4) on shared stimulus.
// Table vectors for the basic drains, hand sequences for corner cases, then random
// traffic checked against a queue-based reference model.
module tb_psum_drain;

   localparam int NL = 4;
   localparam int PW = 32;
   localparam int OW = 16;

   logic             clk;
   logic             rst;
   logic             start;
   logic             rdy;
   logic [NL*PW-1:0] psum;

   logic          o0_flush, o0_valid, o0_last, o0_busy, o0_done, o0_err;
   logic [OW-1:0] o0_data;
   logic          o4_flush, o4_valid, o4_last, o4_busy, o4_done, o4_err;
   logic [OW-1:0] o4_data;

   psum_drain #(.NUM_LANE(NL), .PSUM_W(PW), .OUT_W(OW), .SHIFT(0)) dut0 (
      .CLK(clk), .RST(rst), .drain_start(start), .psum_in(psum),
      .acc_flush(o0_flush), .out_valid(o0_valid), .out_ready(rdy),
      .out_data(o0_data), .out_last(o0_last), .busy(o0_busy),
      .done(o0_done), .err_overrun(o0_err)
   );

   psum_drain #(.NUM_LANE(NL), .PSUM_W(PW), .OUT_W(OW), .SHIFT(4)) dut4 (
      .CLK(clk), .RST(rst), .drain_start(start), .psum_in(psum),
      .acc_flush(o4_flush), .out_valid(o4_valid), .out_ready(rdy),
      .out_data(o4_data), .out_last(o4_last), .busy(o4_busy),
      .done(o4_done), .err_overrun(o4_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
   endtask

   // ---------------- reference model ----------------
   // Expected words of the drain in progress, front = word currently offered.
   logic [15:0] q0[$];
   logic [15:0] q4[$];
   bit m_busy = 0;
   bit m_done = 0;
   bit m_err  = 0;

   function automatic logic [15:0] rq(input logic [31:0] p, input int sh);
      longint      t;
      logic [63:0] tv;
      t = longint'($signed(p)) >>> sh;
`ifdef PSUM_DRAIN_SAT_EN
      if (t > 32767)  t = 32767;
      if (t < -32768) t = -32768;
`endif
      tv = t;
      return tv[15:0];
   endfunction

   // Called at the negedge: compare every output with the model, then advance
   // the model across the next posedge using the inputs held there.
   task automatic step_model();
      bit          ef;
      bit          nd;
      ef = start && !m_busy && !rst;
      chk("flush0", o0_flush, ef);
      chk("flush4", o4_flush, ef);
      chk("valid0", o0_valid, m_busy);
      chk("valid4", o4_valid, m_busy);
      chk("busy0",  o0_busy,  m_busy);
      chk("done0",  o0_done,  m_done);
      chk("done4",  o4_done,  m_done);
      chk("err0",   o0_err,   m_err);
      chk("err4",   o4_err,   m_err);
      if (m_busy) begin
         chk("data0", o0_data, q0[0]);
         chk("data4", o4_data, q4[0]);
         chk("last0", o0_last, q0.size() == 1);
         chk("last4", o4_last, q4.size() == 1);
      end
      @(posedge clk);
      if (rst) begin
         q0.delete(); q4.delete();
         m_busy = 0; m_done = 0; m_err = 0;
      end else begin
         nd = 0;
         if (!m_busy) begin
            if (start) begin
               for (int i = 0; i < NL; i++) begin
                  q0.push_back(rq(psum[i*PW +: PW], 0));
                  q4.push_back(rq(psum[i*PW +: PW], 4));
               end
               m_busy = 1;
            end
         end else begin
            if (start) m_err = 1;
            if (rdy) begin
               void'(q0.pop_front());
               void'(q4.pop_front());
               if (q0.size() == 0) begin
                  m_busy = 0;
                  nd = 1;
               end
            end
         end
         m_done = nd;
      end
      #1;
   endtask

   task automatic cyc();
      @(negedge clk);
      step_model();
   endtask

   task automatic set_lanes(input logic [31:0] l0, input logic [31:0] l1,
                            input logic [31:0] l2, input logic [31:0] l3);
      psum = {l3, l2, l1, l0};
   endtask

   task automatic drain_out();
      start = 0; rdy = 1;
      for (int k = 0; k < 10 && m_busy; k++) cyc();
      cyc();  // done cycle
   endtask

   function automatic logic [31:0] rnd_lane();
      case ($urandom_range(0, 2))
         0:       return 32'($signed($urandom_range(0, 200)) - 100);
         1:       return 32'($signed($urandom_range(0, 140000)) - 70000);
         default: return $urandom;
      endcase
   endfunction

   // ---------------- vector table ----------------
   typedef struct {
      bit          rst, start, rdy;
      bit          e_flush, e_valid, e_last, e_done;
      logic [15:0] e_data;
   } vec_t;

   function automatic vec_t mk(bit r, bit s, bit y, bit f, bit v, bit l, bit d, logic [15:0] dat);
      vec_t x;
      x.rst = r; x.start = s; x.rdy = y;
      x.e_flush = f; x.e_valid = v; x.e_last = l; x.e_done = d; x.e_data = dat;
      return x;
   endfunction

   vec_t tbl[$];

   initial begin
      // Drain with out_ready held high.
      tbl.push_back(mk(0,1,1, 1,0,0,0, 0));
      tbl.push_back(mk(0,0,1, 0,1,0,0, 1));
      tbl.push_back(mk(0,0,1, 0,1,0,0, 2));
      tbl.push_back(mk(0,0,1, 0,1,0,0, 3));
      tbl.push_back(mk(0,0,1, 0,1,1,0, 4));
      tbl.push_back(mk(0,0,1, 0,0,0,1, 0));
      tbl.push_back(mk(0,0,0, 0,0,0,0, 0));
      // Drain with out_ready toggling 1,0,0,1,...
      tbl.push_back(mk(0,1,0, 1,0,0,0, 0));
      tbl.push_back(mk(0,0,1, 0,1,0,0, 1));
      tbl.push_back(mk(0,0,0, 0,1,0,0, 2));
      tbl.push_back(mk(0,0,0, 0,1,0,0, 2));
      tbl.push_back(mk(0,0,1, 0,1,0,0, 2));
      tbl.push_back(mk(0,0,0, 0,1,0,0, 3));
      tbl.push_back(mk(0,0,0, 0,1,0,0, 3));
      tbl.push_back(mk(0,0,1, 0,1,0,0, 3));
      tbl.push_back(mk(0,0,0, 0,1,1,0, 4));
      tbl.push_back(mk(0,0,0, 0,1,1,0, 4));
      tbl.push_back(mk(0,0,1, 0,1,1,0, 4));
      tbl.push_back(mk(0,0,0, 0,0,0,1, 0));

      // ---------------- reset ----------------
      rst = 1; start = 1; rdy = 1;
      set_lanes(1, 2, 3, 4);
      @(negedge clk);
      chk("rst_flush_held", o0_flush, 0);
      chk("rst_valid", o0_valid, 0);
      step_model();
      cyc();
      rst = 0; start = 0;
      @(negedge clk);
      chk("rst_busy", o0_busy, 0);
      chk("rst_done", o0_done, 0);
      chk("rst_err",  o0_err,  0);
      step_model();

      // ---------------- table ----------------
      foreach (tbl[i]) begin
         rst = tbl[i].rst; start = tbl[i].start; rdy = tbl[i].rdy;
         @(negedge clk);
         chk($sformatf("tbl%0d_flush", i), o0_flush, tbl[i].e_flush);
         chk($sformatf("tbl%0d_valid", i), o0_valid, tbl[i].e_valid);
         chk($sformatf("tbl%0d_done",  i), o0_done,  tbl[i].e_done);
         if (tbl[i].e_valid) begin
            chk($sformatf("tbl%0d_data", i), o0_data, tbl[i].e_data);
            chk($sformatf("tbl%0d_last", i), o0_last, tbl[i].e_last);
         end
         step_model();
      end

      // ---------------- overrun during SEND ----------------
      start = 1; rdy = 1;
      cyc();                         // capture
      start = 0; cyc();              // lane 0
      start = 1;
      @(negedge clk);
      chk("ovr_no_flush", o0_flush, 0);
      chk("ovr_data", o0_data, 16'd2);
      step_model();                  // lane 1 with start asserted
      start = 0;
      @(negedge clk);
      chk("ovr_err_set", o0_err, 1);
      chk("ovr_stream_ok", o0_data, 16'd3);
      step_model();
      cyc();                         // lane 3
      // start during final handshake is ignored; during done cycle it is accepted
      start = 1; rdy = 1;
      cyc();                         // capture again
      start = 0; cyc(); cyc(); cyc();
      start = 1;
      @(negedge clk);
      chk("fin_last", o0_last, 1);
      chk("fin_no_flush", o0_flush, 0);
      step_model();
      @(negedge clk);
      chk("donecyc_done", o0_done, 1);
      chk("donecyc_flush", o0_flush, 1);
      step_model();
      drain_out();
      chk("err_sticky", o0_err, 1);
      rst = 1; cyc(); rst = 0;
      @(negedge clk);
      chk("err_cleared", o0_err, 0);
      step_model();

      // ---------------- saturate / truncate ----------------
      set_lanes(32'd40000, -32'sd40000, 32'd7, -32'sd17);
      start = 1; rdy = 1; cyc();
      start = 0;
      @(negedge clk);
`ifdef PSUM_DRAIN_SAT_EN
      chk("sat_pos", o0_data, 16'h7FFF);
`else
      chk("trunc_pos", o0_data, 16'h9C40);
`endif
      chk("shift4_pos", o4_data, 16'h09C4);
      step_model();
      @(negedge clk);
`ifdef PSUM_DRAIN_SAT_EN
      chk("sat_neg", o0_data, 16'h8000);
`else
      chk("trunc_neg", o0_data, 16'h63C0);
`endif
      chk("shift4_neg", o4_data, 16'hF63C);
      step_model();
      cyc();
      @(negedge clk);
      chk("ashr_m17", o4_data, 16'hFFFE);
      chk("noshift_m17", o0_data, 16'hFFEF);
      step_model();
      cyc();

      // ---------------- reset mid-drain ----------------
      set_lanes(1, 2, 3, 4);
      start = 1; rdy = 1; cyc();
      start = 0; cyc(); cyc();
      rst = 1;
      @(negedge clk);
      chk("abort_pre_data", o0_data, 16'd3);
      step_model();
      rst = 0;
      @(negedge clk);
      chk("abort_valid", o0_valid, 0);
      chk("abort_busy",  o0_busy,  0);
      step_model();
      set_lanes(10, 20, 30, 40);
      start = 1; cyc();
      start = 0;
      @(negedge clk);
      chk("fresh_lane0", o0_data, 16'd10);
      step_model();
      drain_out();

      // ---------------- random traffic ----------------
      for (int n = 0; n < 600; n++) begin
         rst   = ($urandom_range(0, 79) == 0);
         start = ($urandom_range(0, 5) == 0);
         rdy   = ($urandom_range(0, 2) != 0);
         set_lanes(rnd_lane(), rnd_lane(), rnd_lane(), rnd_lane());
         cyc();
      end
      rst = 0; start = 0;
      drain_out();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
